// File: rtl/sfr_pkg.sv
// Shared SFR definitions: default bus widths and the arbiter state encoding.
package sfr_pkg;

  localparam int SFR_ADDR_WIDTH = 8;
  localparam int SFR_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SFR_ARB_IDLE  = 2'd0,
    SFR_ARB_ISSUE = 2'd1,
    SFR_ARB_WAIT  = 2'd2
  } sfr_arb_state_t;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfr_arbiter_if.sv
// Requester-side and SFR-side signals of the SFR port arbiter.
interface sfr_arbiter_if
  import sfr_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = SFR_ADDR_WIDTH,
  parameter int DATA_WIDTH = SFR_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          sfr_en;
  logic                          sfr_we;
  logic [ADDR_WIDTH-1:0]         sfr_addr;
  logic [DATA_WIDTH-1:0]         sfr_wdata;
  logic [DATA_WIDTH-1:0]         sfr_rdata;

  // Arbiter view.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, sfr_rdata,
    output req_ready, rsp_valid, rsp_rdata, sfr_en, sfr_we, sfr_addr, sfr_wdata
  );

  // Requesters plus SFR file view.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, sfr_rdata,
    input  req_ready, rsp_valid, rsp_rdata, sfr_en, sfr_we, sfr_addr, sfr_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping to bit 0.
module rr_arbiter #(
  parameter int WIDTH = 2,
  parameter int IDX_W = 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [WIDTH-1:0] hi_req;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign hi_req[gi] = req[gi] && (gi >= int'(ptr));
  end

  // Lowest request at/after ptr wins; otherwise lowest request overall (wrap).
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (hi_req[i]) idx = IDX_W'(i);
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/sfr_arbiter.sv
// Single-port SFR arbiter: requester 0 has fixed priority, the rest share
// round-robin; one transaction in flight, response routed to its owner.
module sfr_arbiter
  import sfr_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = SFR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SFR_DATA_WIDTH,
  parameter int SFR_RD_LATENCY = 1
) (
  input logic          clock,
  input logic          reset,
  sfr_arbiter_if.slave bus
);

  localparam int REQ_W = idx_width(NUM_REQ);
  localparam int SUB_N = NUM_REQ - 1;
  localparam int SUB_W = idx_width(SUB_N);
  localparam logic [1:0] CNT_LOAD = 2'(SFR_RD_LATENCY - 1);

  sfr_arb_state_t state_reg, state_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic [REQ_W-1:0]      rr_ptr_reg;
  logic [REQ_W-1:0]      owner_reg;
  logic                  write_reg;
  logic                  rsp_read_reg;
  logic                  sfr_en_reg, sfr_we_reg;
  logic [ADDR_WIDTH-1:0] sfr_addr_reg;
  logic [DATA_WIDTH-1:0] sfr_wdata_reg;
  logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [SUB_N-1:0]      sub_grant;
  logic [SUB_W-1:0]      sub_ptr, sub_idx;
  logic                  sub_any;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [REQ_W-1:0]      winner_idx;
  logic                  winner_write;
  logic                  accept;
  logic                  rsp_fire;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // rr_ptr counts requesters 1..NUM_REQ-1; the sub-arbiter indexes from 0.
  assign sub_ptr = SUB_W'(rr_ptr_reg - REQ_W'(1));

  rr_arbiter #(
    .WIDTH (SUB_N),
    .IDX_W (SUB_W)
  ) u_rr (
    .req   (bus.req_valid[NUM_REQ-1:1]),
    .ptr   (sub_ptr),
    .grant (sub_grant),
    .idx   (sub_idx),
    .any   (sub_any)
  );

  always_comb begin
    if (bus.req_valid[0]) begin
      grant      = NUM_REQ'(1);
      winner_idx = '0;
    end else begin
      grant      = {sub_grant, 1'b0};
      winner_idx = REQ_W'(sub_idx) + REQ_W'(1);
    end
  end

  assign grant_any    = bus.req_valid[0] | sub_any;
  assign winner_write = bus.req_write[winner_idx];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      SFR_ARB_IDLE: begin
        if (grant_any) begin
          accept     = 1'b1;
          state_next = SFR_ARB_ISSUE;
        end
      end
      SFR_ARB_ISSUE: begin
        cnt_next   = CNT_LOAD;
        state_next = SFR_ARB_WAIT;
      end
      SFR_ARB_WAIT: begin
        if (cnt_reg == 2'd0) state_next = SFR_ARB_IDLE;
        else                 cnt_next   = cnt_reg - 2'd1;
      end
      default: state_next = SFR_ARB_IDLE;
    endcase
    // Response flags are loaded one cycle early so they line up with the
    // final WAIT cycle, where sfr_rdata is valid.
    rsp_fire = (state_next == SFR_ARB_WAIT) && (cnt_next == 2'd0);
  end

  assign rsp_valid_next = rsp_fire ? (NUM_REQ'(1) << owner_reg) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= SFR_ARB_IDLE;
      cnt_reg       <= '0;
      rr_ptr_reg    <= REQ_W'(1);
      owner_reg     <= '0;
      write_reg     <= 1'b0;
      rsp_read_reg  <= 1'b0;
      rsp_valid_reg <= '0;
      sfr_en_reg    <= 1'b0;
      sfr_we_reg    <= 1'b0;
      sfr_addr_reg  <= '0;
      sfr_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_read_reg  <= rsp_fire & ~write_reg;
      sfr_en_reg    <= accept;
      sfr_we_reg    <= accept & winner_write;
      sfr_addr_reg  <= accept ? addr_arr[winner_idx] : '0;
      sfr_wdata_reg <= (accept && winner_write) ? wdata_arr[winner_idx] : '0;
      if (accept) begin
        owner_reg <= winner_idx;
        write_reg <= winner_write;
        if (!bus.req_valid[0]) begin
          rr_ptr_reg <= (winner_idx == REQ_W'(NUM_REQ - 1)) ? REQ_W'(1)
                                                             : winner_idx + REQ_W'(1);
        end
      end
    end
  end

  assign bus.req_ready = (state_reg == SFR_ARB_IDLE && !reset) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_reg;
  // Read data is passed through from the SFR file, gated by a registered flag.
  assign bus.rsp_rdata = rsp_read_reg ? bus.sfr_rdata : '0;
  assign bus.sfr_en    = sfr_en_reg;
  assign bus.sfr_we    = sfr_we_reg;
  assign bus.sfr_addr  = sfr_addr_reg;
  assign bus.sfr_wdata = sfr_wdata_reg;

endmodule

// File: tb/tb_sfr_arbiter.sv
// Directed bench for sfr_arbiter: one instance at latency 1, one at latency 3,
// each with a small SFR model and a response scoreboard.
module tb_sfr_arbiter;

  typedef struct {
    int          req;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  rsp_t qa[$];
  rsp_t qb[$];
  logic [2:0] rdy;
  int rr_seq [4] = '{1, 2, 1, 2};

  always #5 clk = ~clk;

  sfr_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) ifa ();
  sfr_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) ifb ();

  sfr_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SFR_RD_LATENCY(1)) dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  sfr_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SFR_RD_LATENCY(3)) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, a};
  endfunction

  // SFR model A: latency 1, writable.
  logic [31:0]  mem_a [256];
  logic [255:0] wr_a = '0;
  logic [31:0]  rd_a = '0;
  always @(posedge clk) begin
    if (ifa.sfr_en && ifa.sfr_we) begin
      mem_a[ifa.sfr_addr] <= ifa.sfr_wdata;
      wr_a[ifa.sfr_addr]  <= 1'b1;
    end
    rd_a <= (ifa.sfr_en && !ifa.sfr_we)
            ? (wr_a[ifa.sfr_addr] ? mem_a[ifa.sfr_addr] : init_val(ifa.sfr_addr)) : 32'h0;
  end
  assign ifa.sfr_rdata = rd_a;

  // SFR model B: latency 3, read-only contents.
  logic [31:0] pb0 = '0, pb1 = '0, pb2 = '0;
  always @(posedge clk) begin
    pb0 <= (ifb.sfr_en && !ifb.sfr_we) ? init_val(ifb.sfr_addr) : 32'h0;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign ifb.sfr_rdata = pb2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (|ifa.rsp_valid) begin
      if (qa.size() == 0) check("a_unexpected_rsp", 32'(ifa.rsp_valid), 32'd0);
      else begin
        e = qa.pop_front();
        check("a_rsp_owner", 32'(ifa.rsp_valid), 32'(3'b001 << e.req));
        check("a_rsp_rdata", ifa.rsp_rdata, e.data);
      end
    end
    if (|ifa.req_ready) check("a_ready_onehot", 32'($countones(ifa.req_ready)), 32'd1);
  end

  always @(negedge clk) begin
    rsp_t e;
    if (|ifb.rsp_valid) begin
      if (qb.size() == 0) check("b_unexpected_rsp", 32'(ifb.rsp_valid), 32'd0);
      else begin
        e = qb.pop_front();
        check("b_rsp_owner", 32'(ifb.rsp_valid), 32'(3'b001 << e.req));
        check("b_rsp_rdata", ifb.rsp_rdata, e.data);
      end
    end
    if (|ifb.req_ready) check("b_ready_onehot", 32'($countones(ifb.req_ready)), 32'd1);
  end

  task automatic set_req(input bit use_b, input int r, input bit w,
                         input logic [7:0] a, input logic [31:0] d);
    if (use_b) begin
      ifb.req_valid = ifb.req_valid | (3'b001 << r);
      ifb.req_write = (ifb.req_write & ~(3'b001 << r)) | (3'(w) << r);
      ifb.req_addr  = (ifb.req_addr & ~(24'hFF << (8*r))) | (24'(a) << (8*r));
      ifb.req_wdata = (ifb.req_wdata & ~(96'(32'hFFFF_FFFF) << (32*r))) | (96'(d) << (32*r));
    end else begin
      ifa.req_valid = ifa.req_valid | (3'b001 << r);
      ifa.req_write = (ifa.req_write & ~(3'b001 << r)) | (3'(w) << r);
      ifa.req_addr  = (ifa.req_addr & ~(24'hFF << (8*r))) | (24'(a) << (8*r));
      ifa.req_wdata = (ifa.req_wdata & ~(96'(32'hFFFF_FFFF) << (32*r))) | (96'(d) << (32*r));
    end
  endtask

  task automatic clr_req(input bit use_b, input int r);
    if (use_b) ifb.req_valid = ifb.req_valid & ~(3'b001 << r);
    else       ifa.req_valid = ifa.req_valid & ~(3'b001 << r);
  endtask

  task automatic wait_rdy(input bit use_b, output logic [2:0] seen);
    seen = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = use_b ? ifb.req_ready : ifa.req_ready;
      if (seen != 3'b000) break;
    end
    check("accept_seen", 32'(seen != 3'b000), 32'd1);
  endtask

  // One transaction on instance A with cycle-exact checks of the sfr strobe.
  task automatic txn_a(input int r, input bit w, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] rd);
    logic [2:0] seen;
    @(posedge clk); #1;
    set_req(1'b0, r, w, a, d);
    qa.push_back('{r, w ? 32'h0 : rd});
    wait_rdy(1'b0, seen);
    check("txn_ready", 32'(seen), 32'(3'b001 << r));
    @(posedge clk); #1;
    clr_req(1'b0, r);
    @(negedge clk);
    check("txn_sfr_en", 32'(ifa.sfr_en), 32'd1);
    check("txn_sfr_we", 32'(ifa.sfr_we), 32'(w));
    check("txn_sfr_addr", 32'(ifa.sfr_addr), 32'(a));
    check("txn_sfr_wdata", ifa.sfr_wdata, w ? d : 32'h0);
    check("txn_ready_busy", 32'(ifa.req_ready), 32'd0);
    @(negedge clk);
    check("txn_rsp_timing", 32'(ifa.rsp_valid), 32'(3'b001 << r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.req_valid = '0; ifa.req_write = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = '0; ifb.req_write = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", 32'(ifa.req_ready), 32'd0);
    check("rst_a_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    check("rst_a_rsp_rdata", ifa.rsp_rdata, 32'd0);
    check("rst_a_sfr_en", 32'(ifa.sfr_en), 32'd0);
    check("rst_a_sfr_we", 32'(ifa.sfr_we), 32'd0);
    check("rst_a_sfr_addr", 32'(ifa.sfr_addr), 32'd0);
    check("rst_a_sfr_wdata", ifa.sfr_wdata, 32'd0);
    check("rst_a_rr_ptr", 32'(dut_a.rr_ptr_reg), 32'd1);
    check("rst_b_sfr_en", 32'(ifb.sfr_en), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Single read, write, read-back on latency 1.
    txn_a(1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    txn_a(2, 1'b1, 8'h04, 32'h0000_00A5, 32'h0);
    txn_a(2, 1'b0, 8'h04, 32'h0, 32'h0000_00A5);

    // Requester 0 keeps winning while valid; then 1 and 2 alternate.
    @(posedge clk); #1;
    set_req(1'b0, 0, 1'b0, 8'h40, 32'h0);
    set_req(1'b0, 1, 1'b0, 8'h41, 32'h0);
    set_req(1'b0, 2, 1'b0, 8'h42, 32'h0);
    for (int g = 0; g < 4; g++) qa.push_back('{0, init_val(8'h40)});
    for (int g = 0; g < 4; g++) begin
      wait_rdy(1'b0, rdy);
      check("prio_grant", 32'(rdy), 32'd1);
    end
    @(posedge clk); #1;
    clr_req(1'b0, 0);
    check("prio_rr_ptr", 32'(dut_a.rr_ptr_reg), 32'd1);
    for (int g = 0; g < 4; g++) qa.push_back('{rr_seq[g], init_val(8'h40 + 8'(rr_seq[g]))});
    for (int g = 0; g < 4; g++) begin
      wait_rdy(1'b0, rdy);
      check("rr_grant", 32'(rdy), 32'(3'b001 << rr_seq[g]));
    end
    @(posedge clk); #1;
    clr_req(1'b0, 1);
    clr_req(1'b0, 2);

    // Latency 3: response at N+4, next accept at N+5.
    @(posedge clk); #1;
    set_req(1'b1, 1, 1'b0, 8'h20, 32'h0);
    qb.push_back('{1, init_val(8'h20)});
    wait_rdy(1'b1, rdy);
    check("lat_accept", 32'(rdy), 32'd2);
    @(posedge clk); #1;
    clr_req(1'b1, 1);
    set_req(1'b1, 2, 1'b0, 8'h21, 32'h0);
    qb.push_back('{2, init_val(8'h21)});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("lat_ready_low", 32'(ifb.req_ready), 32'd0);
      check("lat_sfr_en", 32'(ifb.sfr_en), 32'(k == 1));
      check("lat_rsp_valid", 32'(ifb.rsp_valid), (k == 4) ? 32'd2 : 32'd0);
    end
    @(negedge clk);
    check("lat_next_accept", 32'(ifb.req_ready), 32'd4);
    @(posedge clk); #1;
    clr_req(1'b1, 2);
    repeat (6) @(negedge clk);

    // Reset one cycle after sfr_en drops the in-flight response.
    @(posedge clk); #1;
    set_req(1'b1, 1, 1'b0, 8'h30, 32'h0);
    wait_rdy(1'b1, rdy);
    check("rst_accept", 32'(rdy), 32'd2);
    @(posedge clk); #1;
    clr_req(1'b1, 1);
    @(negedge clk);
    check("rst_sfr_en_pre", 32'(ifb.sfr_en), 32'd1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_rsp_valid", 32'(ifb.rsp_valid), 32'd0);
      check("rst_mid_rsp_rdata", ifb.rsp_rdata, 32'd0);
      check("rst_mid_sfr_en", 32'(ifb.sfr_en), 32'd0);
      check("rst_mid_sfr_addr", 32'(ifb.sfr_addr), 32'd0);
      check("rst_mid_ready", 32'(ifb.req_ready), 32'd0);
    end
    check("rst_mid_rr_ptr", 32'(dut_b.rr_ptr_reg), 32'd1);
    @(posedge clk); #1;
    set_req(1'b1, 1, 1'b0, 8'h31, 32'h0);
    set_req(1'b1, 2, 1'b0, 8'h32, 32'h0);
    qb.push_back('{1, init_val(8'h31)});
    qb.push_back('{2, init_val(8'h32)});
    wait_rdy(1'b1, rdy);
    check("post_rst_grant1", 32'(rdy), 32'd2);
    @(posedge clk); #1;
    clr_req(1'b1, 1);
    wait_rdy(1'b1, rdy);
    check("post_rst_grant2", 32'(rdy), 32'd4);
    @(posedge clk); #1;
    clr_req(1'b1, 2);
    repeat (8) @(negedge clk);

    check("a_scoreboard_drained", 32'(qa.size()), 32'd0);
    check("b_scoreboard_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
